ct_f_spsram_param: RTL
======================

CT_F_SPSRAM_PARAM -- requirements
Module: ct_f_spsram_param

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, address bus width.
REQ-002 Parameter DATA_WIDTH, default 128, data and bit-mask width.
REQ-003 Parameter DEPTH, default 65536, number of words; legal range 2..2^ADDR_WIDTH.
REQ-004 Parameter OUT_REG, default 0, 1 adds one output pipeline register.
REQ-005 CLK  input  1  single clock, all logic on posedge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 A  input  ADDR_WIDTH  word address.
REQ-008 CEN  input  1  chip enable, active-low.
REQ-009 GWEN  input  1  global write enable, active-low.
REQ-010 WEN  input  DATA_WIDTH  per-bit write enable, active-low.
REQ-011 D  input  DATA_WIDTH  write data.
REQ-012 Q  output  DATA_WIDTH  read data.
REQ-013 BUSY  output  1  high while the post-reset clear sweep runs.
REQ-014 ERR  output  1  sticky out-of-range access flag.
REQ-015 A_t0, CEN_t0, GWEN_t0, WEN_t0, D_t0  input  same widths as A, CEN, GWEN, WEN, D  taint of each input.
REQ-016 Q_t0  output  DATA_WIDTH  taint of Q.

Function
REQ-017 Access cycle when CEN=0 and BUSY=0; CEN=1 is idle, memory and Q unchanged.
REQ-018 Write when access and GWEN=0: bit i of word A written with D[i] only where WEN[i]=0.
REQ-019 Read latency: Q shows word A 1 cycle after the access edge (OUT_REG=0), 2 cycles (OUT_REG=1).
REQ-020 Write cycle is read-first: Q shows the pre-write contents of word A at the normal latency.
REQ-021 Q holds its last value through idle cycles and until the next access result reaches it.
REQ-022 Access with A >= DEPTH: write dropped, read returns all-zero, ERR set next edge.
REQ-023 ERR stays set until RST; simultaneous out-of-range access and RST leaves ERR=0.
REQ-024 FSM states INIT and RUN; INIT writes zero to words 0..DEPTH-1, one per cycle, using an internal counter.
REQ-025 INIT -> RUN on the edge after the counter writes word DEPTH-1; BUSY=1 exactly DEPTH cycles after RST deasserts.
REQ-026 Accesses during BUSY are ignored: no write, Q unchanged, ERR unchanged.
REQ-027 Counter width ceil(log2(DEPTH)); no wrap past DEPTH-1.

Reset
REQ-028 RST high at a posedge: Q=0, Q_t0=0, ERR=0, BUSY=1, state INIT, counter=0.
REQ-029 RST mid-sweep or mid-read restarts the sweep from word 0; an in-flight read result is discarded.
REQ-030 Memory array has no reset path other than the INIT sweep.

Configuration
REQ-031 Macro SPSRAM_TAINT_EN defined: DEPTH x DATA_WIDTH shadow array updated in lockstep with data.
REQ-032 With SPSRAM_TAINT_EN, written shadow bit i = D_t0[i] | WEN_t0[i] | GWEN_t0 | CEN_t0 | (|A_t0).
REQ-033 With SPSRAM_TAINT_EN, Q_t0 = shadow word read | {DATA_WIDTH{|A_t0 of that access}}, same latency as Q; INIT clears the shadow to zero.
REQ-034 Without SPSRAM_TAINT_EN: no shadow array, Q_t0 tied to all-zero, taint inputs unused.

Verification
REQ-035 DEPTH=16, DATA_WIDTH=8: RST 1 cycle -> BUSY high exactly 16 cycles, then every read returns 8'h00.
REQ-036 Write A=3 D=8'hA5 WEN=8'h00, then read A=3 -> Q=8'hA5 after 1 cycle (OUT_REG=0), 2 cycles (OUT_REG=1).
REQ-037 Word 3=8'hA5; write D=8'hFF WEN=8'hF0 -> Q shows 8'hA5 (read-first); next read -> 8'hAF.
REQ-038 Read A=20 with DEPTH=16 -> Q=8'h00, ERR=1 next edge, stays 1; CEN=1 for 5 cycles -> Q holds.
REQ-039 RST asserted at sweep counter=7 -> sweep restarts at 0, BUSY high 16 more cycles, ERR=0.
REQ-040 SPSRAM_TAINT_EN: write A=5 D_t0=8'h01, read A=5 -> Q_t0=8'h01; read with A_t0=1 -> Q_t0=8'hFF; macro undefined -> Q_t0=8'h00.

Source files
------------

// File: rtl/ct_f_spsram_param.sv
// Single-port SRAM with per-bit write mask, read-first writes, post-reset zero sweep and sticky range error.
// Optional taint shadow array enabled by defining SPSRAM_TAINT_EN.
module ct_f_spsram_param #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 65536,
  parameter int OUT_REG    = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  BUSY,
  output logic                  ERR,
  input  logic [ADDR_WIDTH-1:0] A_t0,
  input  logic                  CEN_t0,
  input  logic                  GWEN_t0,
  input  logic [DATA_WIDTH-1:0] WEN_t0,
  input  logic [DATA_WIDTH-1:0] D_t0,
  output logic [DATA_WIDTH-1:0] Q_t0
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_err;

  logic            w_access;
  logic            w_in_range;
  logic [CW-1:0]   w_idx;
  logic            w_sweep;
  logic            w_mem_we;
  logic [CW-1:0]   w_waddr;
  logic [DATA_WIDTH-1:0] w_bm;
  logic [DATA_WIDTH-1:0] w_wdata;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] w_rd_t;
  logic                  r_rd_v;

  assign w_in_range = ({1'b0, A} < DEPTH_L);
  assign w_idx      = A[CW-1:0];
  assign w_access   = !CEN && !r_busy && !RST;
  assign w_sweep    = r_busy && !RST;

  // The sweep and normal writes share one write port; the sweep writes a whole word of zeros.
  always_comb begin
    w_mem_we = 1'b0;
    w_waddr  = w_idx;
    w_bm     = ~WEN;
    w_wdata  = D;
    if (w_sweep) begin
      w_mem_we = 1'b1;
      w_waddr  = r_cnt;
      w_bm     = '1;
      w_wdata  = '0;
    end else if (w_access && !GWEN && w_in_range) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_cnt == LAST_IDX) begin
            r_state <= S_RUN;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_access && !w_in_range) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (w_bm[i]) r_mem[w_waddr][i] <= w_wdata[i];
      end
    end
  end

  // Read-first: the read register samples the array before this edge's write lands.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd   <= '0;
      r_rd_v <= 1'b0;
    end else begin
      r_rd_v <= w_access;
      if (w_access) r_rd <= w_in_range ? r_mem[w_idx] : '0;
    end
  end

`ifdef SPSRAM_TAINT_EN
  logic [DATA_WIDTH-1:0] r_tmem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_t;
  logic [DATA_WIDTH-1:0] w_twdata;
  logic                  w_taint_ctl;

  assign w_taint_ctl = GWEN_t0 | CEN_t0 | (|A_t0);
  assign w_twdata    = w_sweep ? '0 : (D_t0 | WEN_t0 | {DATA_WIDTH{w_taint_ctl}});

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (w_bm[i]) r_tmem[w_waddr][i] <= w_twdata[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_t <= '0;
    end else if (w_access) begin
      r_rd_t <= (w_in_range ? r_tmem[w_idx] : '0) | {DATA_WIDTH{|A_t0}};
    end
  end

  assign w_rd_t = r_rd_t;
`else
  logic w_unused_taint;
  assign w_unused_taint = ^{A_t0, CEN_t0, GWEN_t0, WEN_t0, D_t0};
  assign w_rd_t = '0;
`endif

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_q;
      logic [DATA_WIDTH-1:0] r_q_t;
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_q   <= '0;
          r_q_t <= '0;
        end else if (r_rd_v) begin
          r_q   <= r_rd;
          r_q_t <= w_rd_t;
        end
      end
      assign Q    = r_q;
      assign Q_t0 = r_q_t;
    end else begin : g_no_out_reg
      assign Q    = r_rd;
      assign Q_t0 = w_rd_t;
    end
  endgenerate

  assign BUSY = r_busy;
  assign ERR  = r_err;

endmodule
